// File: rtl/inst_fetch_enum.sv
// inst_fetch_enum: shared state type, length encoding and compressed-instruction test for inst_fetch.
package inst_fetch_enum;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        VALID,
        DRAIN
    } inst_fetch_state_t;

    localparam logic [1:0] INST_LEN_32 = 2'b11;

    function automatic logic inst_is_comp(input logic [15:0] h);
        return h[1:0] != INST_LEN_32;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: fetches word-aligned instruction memory, keeps a one-word line buffer and
// extracts 16-bit compressed or 32-bit (possibly word-straddling) instructions.
module inst_fetch
    import inst_fetch_enum::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] pc_data_i,
    input  logic            fetch_en_i,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_data_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_comp_o,
    output logic            inst_misalign_o
);

    inst_fetch_state_t state_q, state_d, eval_state;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              buf_valid_q, buf_valid_d;
    logic [XLEN-3:0]   buf_tag_q, buf_tag_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic [15:0]       half_q, half_d;
    logic [31:0]       data_q, data_d;
    logic              comp_q, comp_d;
    logic              mis_q, mis_d;
    logic              hit, pc_b1, eval_comp;
    logic [31:0]       eval_word, eval_data;
    logic [15:0]       eval_h;

    // The aligner serves both a line hit in IDLE (fresh PC, buffered word) and a returning low word.
    assign pc_b1      = (state_q == IDLE) ? pc_data_i[1] : pc_q[1];
    assign eval_word  = (state_q == IDLE) ? buf_data_q : imem_rdata_i;
    assign eval_h     = pc_b1 ? eval_word[31:16] : eval_word[15:0];
    assign eval_comp  = inst_is_comp(eval_h);
    assign eval_state = (eval_comp || !pc_b1) ? VALID : REQ_HI;
    assign eval_data  = eval_comp ? {16'h0000, eval_h} : eval_word;
    assign hit        = buf_valid_q && (buf_tag_q == pc_data_i[XLEN-1:2]);

    assign imem_req_o      = (state_q == REQ_LO) || (state_q == REQ_HI);
    assign imem_addr_o     = imem_req_o ? {pc_q[XLEN-1:2] + (XLEN-2)'(state_q == REQ_HI), 2'b00} : '0;
    assign inst_valid_o    = state_q == VALID;
    assign inst_data_o     = data_q;
    assign inst_pc_o       = pc_q;
    assign inst_comp_o     = comp_q;
    assign inst_misalign_o = mis_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        half_d      = half_q;
        data_d      = data_q;
        comp_d      = comp_q;
        mis_d       = mis_q;
        case (state_q)
            IDLE: begin
                if (fetch_en_i && !flush_i) begin
                    pc_d  = pc_data_i;
                    mis_d = pc_data_i[0];
                    if (pc_data_i[0]) begin
                        state_d = VALID;
                        data_d  = '0;
                        comp_d  = 1'b0;
                    end else if (hit) begin
                        state_d = eval_state;
                        data_d  = eval_data;
                        comp_d  = eval_comp;
                        half_d  = eval_h;
                    end else begin
                        state_d = REQ_LO;
                    end
                end
            end
            REQ_LO:  state_d = flush_i ? IDLE : imem_gnt_i ? WAIT_LO : REQ_LO;
            REQ_HI:  state_d = flush_i ? IDLE : imem_gnt_i ? WAIT_HI : REQ_HI;
            WAIT_LO: begin
                if (flush_i) begin
                    state_d = imem_rvalid_i ? IDLE : DRAIN;
                end else if (imem_rvalid_i) begin
                    buf_valid_d = 1'b1;
                    buf_tag_d   = pc_q[XLEN-1:2];
                    buf_data_d  = imem_rdata_i;
                    state_d     = eval_state;
                    data_d      = eval_data;
                    comp_d      = eval_comp;
                    half_d      = eval_h;
                end
            end
            WAIT_HI: begin
                if (flush_i) begin
                    state_d = imem_rvalid_i ? IDLE : DRAIN;
                end else if (imem_rvalid_i) begin
                    buf_valid_d = 1'b1;
                    buf_tag_d   = pc_q[XLEN-1:2] + (XLEN-2)'(1);
                    buf_data_d  = imem_rdata_i;
                    data_d      = {imem_rdata_i[15:0], half_q};
                    comp_d      = 1'b0;
                    state_d     = VALID;
                end
            end
            VALID:   state_d = (flush_i || inst_ready_i) ? IDLE : VALID;
            DRAIN:   state_d = imem_rvalid_i ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            half_q      <= '0;
            data_q      <= '0;
            comp_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            half_q      <= half_d;
            data_q      <= data_d;
            comp_q      <= comp_d;
            mis_q       <= mis_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a behavioural memory and instruction model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, flush, imem_req, imem_gnt, imem_rvalid;
    logic        inst_valid, inst_ready, inst_comp, inst_mis;
    logic [31:0] pc_data, imem_addr, imem_rdata, inst_data, inst_pc;

    always #5 clk = ~clk;

    inst_fetch #(.XLEN(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pc_data_i(pc_data), .fetch_en_i(fetch_en), .flush_i(flush),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_data_o(inst_data),
        .inst_pc_o(inst_pc), .inst_comp_o(inst_comp), .inst_misalign_o(inst_mis)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        comp;
        logic        mis;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] a1;
        int          lat;
    } exp_t;

    logic [31:0] mem [0:511];
    logic [31:0] addr_log [0:4095];
    exp_t        sb[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          stall_cfg = 0, rv_cfg = 0, rdy_cfg = 0, spur = 0;
    int          hs_total = 0, fetch_base = 0, fetch_cyc = 0, accepted = 0;
    logic        m_lv = 1'b0;
    logic [31:0] m_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[10:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Model: instruction = halfword at pc, plus the next halfword if it is 32-bit; the line
    // buffer is "the last word read from memory".
    task automatic push_exp(input logic [31:0] pc, input int lat);
        exp_t        e;
        logic [15:0] lo;
        logic [31:0] w;
        e.pc = pc; e.lat = lat; e.nreq = 0; e.a0 = '0; e.a1 = '0;
        if (pc[0]) begin
            e.mis = 1'b1; e.data = '0; e.comp = 1'b0;
        end else begin
            lo     = half(pc);
            e.mis  = 1'b0;
            e.comp = lo[1:0] != 2'b11;
            e.data = e.comp ? {16'h0000, lo} : {half(pc + 2), lo};
            w      = pc >> 2;
            if (!(m_lv && m_tag == w)) begin
                e.a0 = w << 2; e.nreq = 1; m_lv = 1'b1; m_tag = w;
            end
            if (!e.comp && pc[1]) begin
                if (e.nreq == 0) e.a0 = (w + 1) << 2;
                else e.a1 = (w + 1) << 2;
                e.nreq++;
                m_tag = w + 1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int lat);
        int acc0;
        @(posedge clk); #1;
        push_exp(pc, lat);
        acc0 = accepted; fetch_base = hs_total; fetch_cyc = cyc;
        pc_data = pc; fetch_en = 1'b1;
        @(posedge clk); #1;
        fetch_en = 1'b0; pc_data = $urandom;
        for (int i = 0; i < 200 && accepted == acc0; i++) begin
            @(posedge clk); #1;
        end
        chk("fetch_done", accepted, acc0 + 1);
    endtask

    // Memory responder: grant after a stall, data after a delay, occasional stray rvalid.
    initial begin
        logic        req_d, gnt_d, pending, waiting;
        logic [31:0] addr_d, pend_addr;
        int          pend_cnt, stall_cnt;
        req_d = 0; gnt_d = 0; pending = 0; waiting = 0; addr_d = 0; pend_addr = 0;
        pend_cnt = 0; stall_cnt = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (req_d && gnt_d) begin
                addr_log[hs_total] = addr_d;
                hs_total++;
                pending = 1; pend_addr = addr_d; waiting = 0;
                pend_cnt = rv_cfg < 0 ? int'($urandom_range(0, 2)) : rv_cfg;
            end
            if (pending && pend_cnt == 0) begin
                imem_rvalid = 1; imem_rdata = mem[pend_addr[10:2]]; pending = 0;
            end else begin
                imem_rvalid = spur != 0 && !pending && $urandom_range(0, 7) == 0;
                imem_rdata  = $urandom;
                if (pending) pend_cnt--;
            end
            if (req_d && !gnt_d && imem_req) chk("addr_stable", imem_addr, addr_d);
            if (imem_req) chk("one_outstanding", {31'b0, pending}, 0);
            if (imem_req) begin
                if (!waiting) begin
                    waiting = 1;
                    stall_cnt = stall_cfg < 0 ? int'($urandom_range(0, 2)) : stall_cfg;
                end
                imem_gnt = stall_cnt == 0;
                if (stall_cnt > 0) stall_cnt--;
            end else begin
                imem_gnt = 0; waiting = 0;
            end
            req_d = imem_req; gnt_d = imem_gnt; addr_d = imem_addr;
        end
    end

    initial begin
        int rdy_cnt;
        rdy_cnt = 0; inst_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (inst_valid && !inst_ready) begin
                if (rdy_cnt > 0) rdy_cnt--;
                else inst_ready = 1;
            end else begin
                inst_ready = 0;
                rdy_cnt = rdy_cfg < 0 ? int'($urandom_range(0, 2)) : rdy_cfg;
            end
        end
    end

    // Monitor: checks hold stability and pops the scoreboard on every accepted instruction.
    initial begin
        logic        hold, pm, first;
        logic [31:0] pd, pp;
        int          lat_meas;
        exp_t        e;
        hold = 0; pm = 0; first = 0; pd = 0; pp = 0; lat_meas = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", {31'b0, inst_valid}, 1);
                chk("hold_data", inst_data, pd);
                chk("hold_pc", inst_pc, pp);
                chk("hold_mis", {31'b0, inst_mis}, {31'b0, pm});
            end
            if (inst_valid && !first) begin
                first = 1; lat_meas = cyc - fetch_cyc;
            end
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_valid: got instruction %h with none expected", inst_data);
                end else begin
                    e = sb.pop_front();
                    chk("inst_data", inst_data, e.data);
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_mis", {31'b0, inst_mis}, {31'b0, e.mis});
                    if (!e.mis) chk("inst_comp", {31'b0, inst_comp}, {31'b0, e.comp});
                    chk("num_requests", hs_total - fetch_base, e.nreq);
                    if (e.nreq > 0) chk("req_addr0", addr_log[fetch_base], e.a0);
                    if (e.nreq > 1) chk("req_addr1", addr_log[fetch_base + 1], e.a1);
                    if (e.lat >= 0) chk("latency", lat_meas, e.lat);
                end
                accepted++;
                first = 0;
            end
            hold = inst_valid && !inst_ready; pd = inst_data; pp = inst_pc; pm = inst_mis;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc, w;
        rst_n = 0; fetch_en = 0; flush = 0; pc_data = 0;
        for (int i = 0; i < 512; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
            mem[i] = w;
        end
        mem[64]  = 32'h12344501;
        mem[128] = 32'h00031111;
        mem[129] = 32'h0000ABCD;
        mem[192] = 32'h00000013;
        mem[256] = 32'h00000001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, inst_valid}, 0);
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_comp", {31'b0, inst_comp}, 0);
        chk("rst_mis", {31'b0, inst_mis}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_valid", {31'b0, inst_valid}, 0);
        chk("idle_req", {31'b0, imem_req}, 0);

        do_fetch(32'h100, 3);
        do_fetch(32'h102, 1);
        do_fetch(32'h202, 5);
        stall_cfg = 3;
        do_fetch(32'h300, 6);
        stall_cfg = 0;

        // Flush while the low word is outstanding; its data must not reach the line buffer.
        rv_cfg = 2;
        @(posedge clk); #1;
        fetch_base = hs_total; pc_data = 32'h400; fetch_en = 1;
        @(posedge clk); #1;
        fetch_en = 0;
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("flush_no_valid", {31'b0, inst_valid}, 0);
        end
        chk("flush_one_req", hs_total - fetch_base, 1);
        chk("flush_req_low", {31'b0, imem_req}, 0);
        rv_cfg = 0;
        do_fetch(32'h400, 3);

        rdy_cfg = 3;
        do_fetch(32'h301, 1);
        chk("idle_after_ready", {31'b0, inst_valid}, 0);

        stall_cfg = -1; rv_cfg = -1; rdy_cfg = -1; spur = 1;
        repeat (150) begin
            pc = 32'h500 + 2 * $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) pc[0] = 1'b1;
            do_fetch(pc, -1);
        end
        spur = 0;
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
